// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch T0-T2, opcode-dependent execute T3-T7, halt and reset handling.
// Optional CTRL_SINGLE_STEP_EN adds a Step input and a Wait state between instructions.
module control_sequencer (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [31:0] IRregister,
  input  logic        CON,
  input  logic        Stop,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic        Step,
`endif
  output logic        Run,
  output logic        HIin,
  output logic        LOin,
  output logic        PCin,
  output logic        MDRin,
  output logic        INPORTin,
  output logic        OUTPORTin,
  output logic        Zin,
  output logic        Yin,
  output logic        MARin,
  output logic        IRin,
  output logic        CONin,
  output logic        HIout,
  output logic        LOout,
  output logic        ZHIout,
  output logic        ZLOout,
  output logic        PCout,
  output logic        MDRout,
  output logic        INPORTout,
  output logic        Cout,
  output logic        Yout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Read,
  output logic        write,
  output logic        IncPC
);

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_T7    = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;
`ifdef CTRL_SINGLE_STEP_EN
  localparam logic [3:0] S_WAIT  = 4'd10;
`endif

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [3:0] state_done;
  logic [4:0] op;
  logic       is_alu, is_imm, is_ldi, is_ld, is_st, is_br, is_long, last_t;
  logic       unused_ir;

  assign unused_ir = ^IRregister[26:0];

  // Opcode is captured as the instruction leaves T2 and held for the execute steps.
  always_ff @(posedge Clock) begin
    if (!Resetn) state <= S_RESET;
    else         state <= state_nxt;
    if (state == S_T2) op <= IRregister[31:27];
  end

  assign is_alu  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign is_imm  = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  assign is_ldi  = (op == OP_LDI);
  assign is_ld   = (op == OP_LD);
  assign is_st   = (op == OP_ST);
  assign is_br   = (op == OP_BR);
  assign is_long = is_alu || is_imm || is_ldi || is_ld || is_st || is_br;

  assign last_t = ((state == S_T3) && !is_long) ||
                  ((state == S_T5) && (is_alu || is_imm || is_ldi)) ||
                  ((state == S_T6) && !(is_ld || is_st)) ||
                  (state == S_T7);

`ifdef CTRL_SINGLE_STEP_EN
  assign state_done = S_WAIT;
`else
  assign state_done = S_T0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET: state_nxt = S_T0;
      S_T0:    state_nxt = S_T1;
      S_T1:    state_nxt = S_T2;
      S_T2:    state_nxt = (IRregister[31:27] == OP_HALT) ? S_HALT : S_T3;
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (last_t) state_nxt = Stop ? S_HALT : state_done;
        else        state_nxt = state + 4'd1;
      end
      S_HALT:  state_nxt = S_HALT;
`ifdef CTRL_SINGLE_STEP_EN
      S_WAIT: begin
        if (Stop)      state_nxt = S_HALT;
        else if (Step) state_nxt = S_T0;
      end
`endif
      default: state_nxt = S_RESET;
    endcase
  end

  // Strobes decode from state plus the captured opcode; only the br PCin also looks at CON.
  always_comb begin
    {HIin, LOin, PCin, MDRin, INPORTin, OUTPORTin, Zin, Yin, MARin, IRin, CONin} = '0;
    {HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, Yout} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, Read, write, IncPC} = '0;
    Run = (state >= S_T0) && (state <= S_T7);
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin ZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_alu || is_imm) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (is_ldi || is_ld || is_st) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        else if (is_br) begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
        else begin
          case (op)
            OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            OP_IN:   begin INPORTout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OUTPORTin = 1'b1; end
            OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T4: begin
        if (is_alu) begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; end
        else if (is_br) begin PCout = 1'b1; Yin = 1'b1; end
        else if (is_imm || is_ldi || is_ld || is_st) begin Cout = 1'b1; Zin = 1'b1; end
      end
      S_T5: begin
        if (is_alu || is_imm || is_ldi) begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_ld || is_st) begin ZLOout = 1'b1; MARin = 1'b1; end
        else if (is_br) begin Cout = 1'b1; Zin = 1'b1; end
      end
      S_T6: begin
        if (is_ld) begin Read = 1'b1; MDRin = 1'b1; end
        else if (is_st) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        else if (is_br) begin ZLOout = 1'b1; PCin = CON; end
      end
      S_T7: begin
        if (is_ld) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_st) write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
